// File: rtl/matrix_multiply_nxn_pkg.sv
// matmul_pkg: FSM state encoding and width helpers shared by the NxN matrix multiplier
package matmul_pkg;
    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    // exact accumulator width for an N-term dot product of DW-bit operands
    function automatic int accw(input int dw, input int n);
        return 2 * dw + clog2(n);
    endfunction
endpackage

// File: rtl/matrix_multiply_nxn_if.sv
// matrix_multiply_nxn_if: start/done handshake and operand/result buses
//   start  request (master -> slave)
//   A, B   row-major NxN operands, DW bits per element (master -> slave)
//   C      row-major NxN result, OW bits per element (slave -> master)
//   busy   operation in progress; done one-cycle completion pulse (slave -> master)
interface matrix_multiply_nxn_if #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int OW = 18
);
    logic                  start;
    logic [N*N*DW-1:0]     A;
    logic [N*N*DW-1:0]     B;
    logic [N*N*OW-1:0]     C;
    logic                  busy;
    logic                  done;
    modport master (output start, A, B, input C, busy, done);
    modport slave  (input start, A, B, output C, busy, done);
endinterface

// File: rtl/matrix_multiply_nxn_mac.sv
// matmul_mac: one multiply-add into an exact accumulator plus reduction to the output width
//   i_a, i_b  DW-bit operands (signed when SIGNED=1)
//   i_acc     running ACCW-bit sum
//   o_sum     i_acc + i_a*i_b, exact in ACCW bits
//   o_res     o_sum reduced to OW bits: clamped with MATMUL_SAT_EN, low bits otherwise
module matmul_mac #(
    parameter int DW     = 8,
    parameter int ACCW   = 18,
    parameter int OW     = 18,
    parameter int SIGNED = 0
) (
    input  logic [DW-1:0]   i_a,
    input  logic [DW-1:0]   i_b,
    input  logic [ACCW-1:0] i_acc,
    output logic [ACCW-1:0] o_sum,
    output logic [OW-1:0]   o_res
);
    logic [ACCW-1:0] w_ax, w_bx;
    // extending both operands to ACCW makes the low ACCW bits of the product exact for either signedness
    assign w_ax  = {{(ACCW-DW){SIGNED != 0 && i_a[DW-1]}}, i_a};
    assign w_bx  = {{(ACCW-DW){SIGNED != 0 && i_b[DW-1]}}, i_b};
    assign o_sum = i_acc + w_ax * w_bx;
    generate
        if (OW > ACCW) begin : g_ext
            assign o_res = {{(OW-ACCW){SIGNED != 0 && o_sum[ACCW-1]}}, o_sum};
        end else if (OW == ACCW) begin : g_eq
            assign o_res = o_sum;
        end else begin : g_red
`ifdef MATMUL_SAT_EN
            if (SIGNED != 0) begin : g_ssat
                logic w_ovf;
                // the value fits when every bit from OW-1 up is a copy of the sign
                assign w_ovf = o_sum[ACCW-1:OW-1] != {(ACCW-OW+1){o_sum[ACCW-1]}};
                assign o_res = !w_ovf ? o_sum[OW-1:0] :
                               o_sum[ACCW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
            end else begin : g_usat
                assign o_res = |o_sum[ACCW-1:OW] ? '1 : o_sum[OW-1:0];
            end
`else
            assign o_res = o_sum[OW-1:0];
`endif
        end
    endgenerate
endmodule

// File: rtl/matrix_multiply_nxn.sv
// matrix_multiply_nxn: sequential C = A x B for NxN matrices, one MAC per cycle, N^3 compute cycles
//   clk, reset  rising-edge clock, synchronous active-high reset
//   bus         slave side of matrix_multiply_nxn_if (start, A, B in; C, busy, done out)
//   MATMUL_SAT_EN defined: C elements clamp to the OW range; undefined: wrap to low OW bits
module matrix_multiply_nxn import matmul_pkg::*; #(
    parameter int N      = 3,
    parameter int DW     = 8,
    parameter int SIGNED = 0,
    parameter int OW     = 2 * DW + clog2(N)
) (
    input logic clk,
    input logic reset,
    matrix_multiply_nxn_if.slave bus
);
    localparam int ACCW = accw(DW, N);
    localparam int IW   = clog2(N);
    state_t            r_state, w_next;
    logic [N*N*DW-1:0] r_a, r_b;
    logic [IW-1:0]     r_i, r_j, r_k;
    logic [ACCW-1:0]   r_acc;
    logic [N*N*OW-1:0] r_c;
    logic [DW-1:0]     w_a, w_b;
    logic [ACCW-1:0]   w_sum;
    logic [OW-1:0]     w_res;
    logic              w_last_k, w_last_j, w_last_i;
    assign w_a      = r_a[DW*(int'(r_i)*N+int'(r_k)) +: DW];
    assign w_b      = r_b[DW*(int'(r_k)*N+int'(r_j)) +: DW];
    assign w_last_k = r_k == IW'(N-1);
    assign w_last_j = r_j == IW'(N-1);
    assign w_last_i = r_i == IW'(N-1);
    matmul_mac #(.DW(DW), .ACCW(ACCW), .OW(OW), .SIGNED(SIGNED)) u_mac (
        .i_a(w_a), .i_b(w_b), .i_acc(r_acc), .o_sum(w_sum), .o_res(w_res)
    );
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_comb begin
        w_next = r_state == IDLE    ? (bus.start ? COMPUTE : IDLE) :
                 r_state == COMPUTE ? (w_last_k && w_last_j && w_last_i ? FINISH : COMPUTE) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
            r_c   <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_a   <= bus.A;
            r_b   <= bus.B;
            r_i   <= '0;
            r_j   <= '0;
            r_k   <= '0;
            r_acc <= '0;
        end else if (r_state == COMPUTE) begin
            r_acc <= w_last_k ? '0 : w_sum;
            r_k   <= w_last_k ? '0 : r_k + 1'b1;
            if (w_last_k) begin
                // the final product is folded in here rather than through r_acc
                r_c[OW*(int'(r_i)*N+int'(r_j)) +: OW] <= w_res;
                r_j <= w_last_j ? '0 : r_j + 1'b1;
                if (w_last_j) r_i <= w_last_i ? '0 : r_i + 1'b1;
            end
        end
    end
    assign bus.C    = r_c;
    assign bus.busy = r_state == COMPUTE;
    assign bus.done = r_state == FINISH;
endmodule

// File: tb/tb_matrix_multiply_nxn.sv
// tb_matrix_multiply_nxn: vector table, random and handshake checks of matrix_multiply_nxn
module tb_matrix_multiply_nxn;
    typedef int arr_t [16];
    typedef struct { arr_t a; arr_t b; arr_t c; } vec_t;
`ifdef MATMUL_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;

    matrix_multiply_nxn_if #(.N(3), .DW(8), .OW(18)) if0 ();
    matrix_multiply_nxn_if #(.N(3), .DW(8), .OW(18)) if1 ();
    matrix_multiply_nxn_if #(.N(3), .DW(8), .OW(16)) if2 ();
    matrix_multiply_nxn_if #(.N(4), .DW(4), .OW(10)) if3 ();
    matrix_multiply_nxn #(.N(3), .DW(8), .SIGNED(0), .OW(18)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
    matrix_multiply_nxn #(.N(3), .DW(8), .SIGNED(1), .OW(18)) dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
    matrix_multiply_nxn #(.N(3), .DW(8), .SIGNED(0), .OW(16)) dut2 (.clk(clk), .reset(reset), .bus(if2.slave));
    matrix_multiply_nxn #(.N(4), .DW(4), .SIGNED(0), .OW(10)) dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

    task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [287:0] pack(input arr_t v, input int n, input int w);
        logic [287:0] p = '0;
        for (int e = 0; e < n * n; e++)
            for (int t = 0; t < w; t++) p[w*e+t] = v[e][t];
        return p;
    endfunction

    function automatic logic [287:0] rep(input longint v, input int n, input int w);
        logic [287:0] p = '0;
        for (int e = 0; e < n * n; e++)
            for (int t = 0; t < w; t++) p[w*e+t] = v[t];
        return p;
    endfunction

    // reference: plain dot products, then range reduction of the exact value
    function automatic logic [287:0] model(input arr_t a, input arr_t b, input int n, input int ow, input bit sg);
        logic [287:0] p = '0;
        longint hi = sg ? (64'sd1 <<< (ow - 1)) - 1 : (64'sd1 <<< ow) - 1;
        longint lo = sg ? -(64'sd1 <<< (ow - 1)) : 0;
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                longint s = 0;
                for (int k = 0; k < n; k++) s += longint'(a[r*n+k]) * longint'(b[k*n+c]);
                if (SAT && s > hi) s = hi;
                if (SAT && s < lo) s = lo;
                for (int t = 0; t < ow; t++) p[ow*(r*n+c)+t] = s[t];
            end
        return p;
    endfunction

    task automatic run0(input arr_t a, input arr_t b, output int lat, output int bn);
        int cnt;
        @(negedge clk);
        if0.A = 72'(pack(a, 3, 8));
        if0.B = 72'(pack(b, 3, 8));
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        cnt = 1;
        bn = 0;
        while (!if0.done && cnt < 200) begin
            bn += int'(if0.busy);
            @(negedge clk);
            cnt++;
        end
        lat = cnt;
    endtask

    task automatic run_par(input arr_t a1, input arr_t b1, input arr_t a2, input arr_t b2,
                           input arr_t a3, input arr_t b3, output int l1, output int l2, output int l3);
        int cnt;
        @(negedge clk);
        if1.A = 72'(pack(a1, 3, 8)); if1.B = 72'(pack(b1, 3, 8));
        if2.A = 72'(pack(a2, 3, 8)); if2.B = 72'(pack(b2, 3, 8));
        if3.A = 64'(pack(a3, 4, 4)); if3.B = 64'(pack(b3, 4, 4));
        if1.start = 1'b1; if2.start = 1'b1; if3.start = 1'b1;
        @(negedge clk);
        if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
        cnt = 1; l1 = 0; l2 = 0; l3 = 0;
        while (cnt < 100 && (l1 == 0 || l2 == 0 || l3 == 0)) begin
            if (if1.done && l1 == 0) l1 = cnt;
            if (if2.done && l2 == 0) l2 = cnt;
            if (if3.done && l3 == 0) l3 = cnt;
            @(negedge clk);
            cnt++;
        end
    endtask

    initial begin
        vec_t tbl [5];
        arr_t a, b, a2, b2, a3, b3, ones, z;
        int   lat, bn, l1, l2, l3, dones;
        int   done_at [$];
        logic [287:0] c_first;
        logic b29, b30;
        z = '{default: 0};
        ones = '{default: 1};
        tbl[0].a = '{0: 1, 4: 1, 8: 1, default: 0};
        tbl[0].b = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
        tbl[0].c = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
        tbl[1].b = '{0: 1, 4: 1, 8: 1, default: 0};
        tbl[1].c = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
        tbl[2].a = '{0: 255, 1: 255, 2: 255, 3: 255, 4: 255, 5: 255, 6: 255, 7: 255, 8: 255, default: 0};
        tbl[2].b = tbl[2].a;
        tbl[2].c = '{0: 195075, 1: 195075, 2: 195075, 3: 195075, 4: 195075, 5: 195075, 6: 195075, 7: 195075, 8: 195075, default: 0};
        tbl[3].a = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0, 0, 0, 0, 0, 0};
        tbl[3].b = '{0: 1, 1: 1, 2: 1, 3: 1, 4: 1, 5: 1, 6: 1, 7: 1, 8: 1, default: 0};
        tbl[3].c = '{6, 6, 6, 15, 15, 15, 24, 24, 24, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].a = z;
        tbl[4].b = '{7, 200, 3, 99, 5, 61, 17, 8, 250, 0, 0, 0, 0, 0, 0, 0};
        tbl[4].c = z;
        reset = 1'b1;
        if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0;
        if0.A = '0; if0.B = '0; if1.A = '0; if1.B = '0;
        if2.A = '0; if2.B = '0; if3.A = '0; if3.B = '0;
        repeat (3) @(negedge clk);
        chk("rst_c0", if0.C, 0);
        chk("rst_c3", if3.C, 0);
        chk("rst_busy_done", {if0.busy, if0.done, if1.busy, if1.done, if2.busy, if2.done, if3.busy, if3.done}, 0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            run0(tbl[i].a, tbl[i].b, lat, bn);
            chk($sformatf("tbl%0d_latency", i), lat, 28);
            chk($sformatf("tbl%0d_busy_cycles", i), bn, 27);
            chk($sformatf("tbl%0d_c", i), if0.C, pack(tbl[i].c, 3, 18));
            @(negedge clk);
            chk($sformatf("tbl%0d_done_pulse", i), if0.done, 0);
        end
        repeat (6) begin
            for (int e = 0; e < 9; e++) begin
                a[e] = int'($urandom_range(0, 255));
                b[e] = int'($urandom_range(0, 255));
            end
            run0(a, b, lat, bn);
            chk("rand_latency", lat, 28);
            chk("rand_c", if0.C, model(a, b, 3, 18, 1'b0));
        end
        // handshake: operands latched, start ignored while busy, held start re-accepted after done
        a = z; b = z; a2 = z; b2 = z;
        for (int e = 0; e < 9; e++) begin
            a[e]  = int'($urandom_range(0, 255)); b[e]  = int'($urandom_range(0, 255));
            a2[e] = int'($urandom_range(0, 255)); b2[e] = int'($urandom_range(0, 255));
        end
        @(negedge clk);
        if0.A = 72'(pack(a, 3, 8)); if0.B = 72'(pack(b, 3, 8));
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        c_first = '0; b29 = 1'b1; b30 = 1'b0;
        for (int cnt = 1; cnt <= 60; cnt++) begin
            if (if0.done) done_at.push_back(cnt);
            if (cnt == 28) c_first = 288'(if0.C);
            if (cnt == 29) b29 = if0.busy;
            if (cnt == 30) b30 = if0.busy;
            if (cnt == 5) begin
                if0.A = 72'(pack(a2, 3, 8));
                if0.B = 72'(pack(b2, 3, 8));
            end
            if (cnt == 10 || cnt == 20) if0.start = 1'b1;
            if (cnt == 11 || cnt == 31) if0.start = 1'b0;
            @(negedge clk);
        end
        chk("hs_done_count", done_at.size(), 2);
        chk("hs_first_done", done_at.size() > 0 ? done_at[0] : -1, 28);
        chk("hs_second_done", done_at.size() > 1 ? done_at[1] : -1, 57);
        chk("hs_latched_c", c_first, model(a, b, 3, 18, 1'b0));
        chk("hs_busy_t29", b29, 0);
        chk("hs_busy_t30", b30, 1);
        chk("hs_second_c", if0.C, model(a2, b2, 3, 18, 1'b0));
        // reset in the middle of a run
        @(negedge clk);
        if0.A = 72'(pack(tbl[3].a, 3, 8)); if0.B = 72'(pack(tbl[3].b, 3, 8));
        if0.start = 1'b1;
        @(negedge clk);
        if0.start = 1'b0;
        dones = 0;
        for (int cnt = 1; cnt <= 40; cnt++) begin
            if (cnt == 10) reset = 1'b1;
            if (cnt == 11) begin
                reset = 1'b0;
                chk("rst_mid_busy_done", {if0.busy, if0.done}, 0);
                chk("rst_mid_c", if0.C, 0);
            end
            dones += int'(if0.done);
            @(negedge clk);
        end
        chk("rst_mid_no_done", dones, 0);
        run0(tbl[0].a, tbl[0].b, lat, bn);
        chk("post_rst_latency", lat, 28);
        chk("post_rst_c", if0.C, pack(tbl[0].c, 3, 18));
        // signed, narrow-output and N=4 instances
        a = '{0: -1, 1: -1, 2: -1, 3: -1, 4: -1, 5: -1, 6: -1, 7: -1, 8: -1, default: 0};
        b = '{0: 2, 1: 2, 2: 2, 3: 2, 4: 2, 5: 2, 6: 2, 7: 2, 8: 2, default: 0};
        run_par(a, b, tbl[2].a, tbl[2].b, ones, ones, l1, l2, l3);
        chk("s_latency", l1, 28);
        chk("s_c", if1.C, rep(64'h3FFFA, 3, 18));
        chk("ov_latency", l2, 28);
        chk("ov_c", if2.C, rep(SAT ? 64'hFFFF : 64'hFA03, 3, 16));
        chk("n4_latency", l3, 65);
        chk("n4_c", if3.C, rep(4, 4, 10));
        repeat (3) begin
            a = z; b = z; a2 = z; b2 = z;
            for (int e = 0; e < 9; e++) begin
                a[e]  = int'($urandom_range(0, 255)) - 128; b[e]  = int'($urandom_range(0, 255)) - 128;
                a2[e] = int'($urandom_range(0, 255));       b2[e] = int'($urandom_range(0, 255));
            end
            for (int e = 0; e < 16; e++) begin
                a3[e] = int'($urandom_range(0, 15));
                b3[e] = int'($urandom_range(0, 15));
            end
            run_par(a, b, a2, b2, a3, b3, l1, l2, l3);
            chk("rs_c", if1.C, model(a, b, 3, 18, 1'b1));
            chk("rov_c", if2.C, model(a2, b2, 3, 16, 1'b0));
            chk("rn4_c", if3.C, model(a3, b3, 4, 10, 1'b0));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
